// File: rtl/br_game_ctrl_if.sv
// BlockyRoads game-flow bus: key events, frame tick, collision in; game state out.
// The hiscore signal exists only when BR_HISCORE_EN is defined.
interface br_game_ctrl_if;
  logic        frame_tick;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_break;
  logic        collision;
  logic [3:0]  status;
  logic [3:0]  direction;
  logic [1:0]  countdown;
  logic [2:0]  level;
  logic [15:0] score;
`ifdef BR_HISCORE_EN
  logic [15:0] hiscore;
`endif

  modport master (
`ifdef BR_HISCORE_EN
    input  hiscore,
`endif
    output frame_tick, key_valid, key_code,
    output key_break, collision,
    input  status, direction, countdown,
    input  level, score
  );

  modport slave (
`ifdef BR_HISCORE_EN
    output hiscore,
`endif
    input  frame_tick, key_valid, key_code,
    input  key_break, collision,
    output status, direction, countdown,
    output level, score
  );
endinterface

// File: rtl/br_game_ctrl.sv
// BlockyRoads game-flow sequencer: FSM, countdown, BCD score, level.
// Optional BR_HISCORE_EN adds a best-score register and port.
module br_game_ctrl #(
  parameter int COUNT_FRAMES = 60,
  parameter int SCORE_DIV    = 6,
  parameter int LEVEL_FRAMES = 600,
  parameter int CRASH_FRAMES = 90
) (
  input  logic          clk,
  input  logic          clr,
  br_game_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CDOWN = 4'd1,
    PLAY  = 4'd2,
    PAUSE = 4'd3,
    CRASH = 4'd4,
    OVER  = 4'd5
  } state_t;

  localparam int CDW = $clog2(COUNT_FRAMES + 1);
  localparam int SDW = $clog2(SCORE_DIV + 1);
  localparam int LDW = $clog2(LEVEL_FRAMES + 1);
  localparam int RDW = $clog2(CRASH_FRAMES + 1);

  localparam logic [CDW-1:0] CD_TOP = CDW'(COUNT_FRAMES - 1);
  localparam logic [SDW-1:0] SD_TOP = SDW'(SCORE_DIV - 1);
  localparam logic [LDW-1:0] LD_TOP = LDW'(LEVEL_FRAMES - 1);
  localparam logic [RDW-1:0] RD_TOP = RDW'(CRASH_FRAMES - 1);

  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_P     = 8'h4D;
  localparam logic [7:0] K_W     = 8'h1D;
  localparam logic [7:0] K_S     = 8'h1B;
  localparam logic [7:0] K_A     = 8'h1C;
  localparam logic [7:0] K_D     = 8'h23;

  state_t         state, state_n;
  logic [CDW-1:0] cdc, cdc_n;
  logic [SDW-1:0] sdc, sdc_n;
  logic [LDW-1:0] ldc, ldc_n;
  logic [RDW-1:0] rdc, rdc_n;
  logic [1:0]     cdv, cdv_n;
  logic [2:0]     lvl, lvl_n;
  logic [15:0]    scr, scr_n;
  logic [15:0]    hi, hi_n;
  logic [3:0]     held, held_n;
  logic [3:0]     dir, dir_n;
  logic [3:0]     steer;
  logic           make, enter_mk, p_mk;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign make     = bus.key_valid & ~bus.key_break;
  assign enter_mk = make & (bus.key_code == K_ENTER);
  assign p_mk     = make & (bus.key_code == K_P);

  // Held keys are tracked regardless of state; bit order {up,down,left,right}.
  always_comb begin
    held_n = held;
    if (bus.key_valid) begin
      unique case (bus.key_code)
        K_W:     held_n[3] = ~bus.key_break;
        K_S:     held_n[2] = ~bus.key_break;
        K_A:     held_n[1] = ~bus.key_break;
        K_D:     held_n[0] = ~bus.key_break;
        default: held_n = held;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    cdc_n   = cdc;
    sdc_n   = sdc;
    ldc_n   = ldc;
    rdc_n   = rdc;
    cdv_n   = cdv;
    lvl_n   = lvl;
    scr_n   = scr;
    hi_n    = hi;
    case (state)
      IDLE: begin
        if (enter_mk) begin
          state_n = CDOWN;
          cdv_n   = 2'd3;
          cdc_n   = '0;
        end
      end
      CDOWN: begin
        if (bus.frame_tick) begin
          if (cdc == CD_TOP) begin
            cdc_n = '0;
            if (cdv == 2'd1) begin
              state_n = PLAY;
              cdv_n   = 2'd0;
              sdc_n   = '0;
              ldc_n   = '0;
            end else begin
              cdv_n = cdv - 2'd1;
            end
          end else begin
            cdc_n = cdc + CDW'(1);
          end
        end
      end
      PLAY: begin
        if (bus.collision) begin
          state_n = CRASH;
          rdc_n   = '0;
        end else if (p_mk) begin
          state_n = PAUSE;
        end else if (bus.frame_tick) begin
          if (sdc == SD_TOP) begin
            sdc_n = '0;
            if (scr != 16'h9999) scr_n = bcd_inc(scr);
          end else begin
            sdc_n = sdc + SDW'(1);
          end
          if (ldc == LD_TOP) begin
            ldc_n = '0;
            if (lvl != 3'd7) lvl_n = lvl + 3'd1;
          end else begin
            ldc_n = ldc + LDW'(1);
          end
        end
      end
      PAUSE: begin
        if (p_mk) state_n = PLAY;
      end
      CRASH: begin
        if (bus.frame_tick) begin
          if (rdc == RD_TOP) begin
            rdc_n   = '0;
            state_n = OVER;
            // Valid packed BCD orders the same as plain binary.
            if (scr > hi) hi_n = scr;
          end else begin
            rdc_n = rdc + RDW'(1);
          end
        end
      end
      OVER: begin
        if (enter_mk) begin
          state_n = IDLE;
          scr_n   = '0;
          lvl_n   = '0;
          sdc_n   = '0;
          ldc_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    steer = held_n;
    if (steer[3] & steer[2]) steer[3:2] = 2'b00;
    if (steer[1] & steer[0]) steer[1:0] = 2'b00;
    dir_n = (state_n == PLAY) ? steer : 4'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cdc   <= '0;
      sdc   <= '0;
      ldc   <= '0;
      rdc   <= '0;
      cdv   <= '0;
      lvl   <= '0;
      scr   <= '0;
      hi    <= '0;
      held  <= '0;
      dir   <= '0;
    end else begin
      state <= state_n;
      cdc   <= cdc_n;
      sdc   <= sdc_n;
      ldc   <= ldc_n;
      rdc   <= rdc_n;
      cdv   <= cdv_n;
      lvl   <= lvl_n;
      scr   <= scr_n;
      hi    <= hi_n;
      held  <= held_n;
      dir   <= dir_n;
    end
  end

  assign bus.status    = state;
  assign bus.direction = dir;
  assign bus.countdown = cdv;
  assign bus.level     = lvl;
  assign bus.score     = scr;
`ifdef BR_HISCORE_EN
  assign bus.hiscore   = hi;
`else
  logic unused_hi;
  assign unused_hi = ^hi;
`endif

endmodule

// File: doc/br_game_ctrl.md
Name: br_game_ctrl

Overview:
Game-flow sequencer for BlockyRoads. It sits between the PS/2 keyboard front end and the Model/Renderer pair. It turns decoded key events, the per-frame tick and the collision flag into the `status` and `direction` buses the rest of the design consumes. It also owns the countdown, BCD score and speed-level counters.

Parameters:
COUNT_FRAMES, 60, frame ticks per countdown step (3→2→1)
SCORE_DIV, 6, frame ticks in PLAY per +1 score
LEVEL_FRAMES, 600, frame ticks in PLAY per level increment
CRASH_FRAMES, 90, frame ticks spent in CRASH before OVER

Ports:
clk  in  1  system clock
clr  in  1  synchronous reset, active-high
frame_tick  in  1  one-cycle pulse per video frame
key_valid  in  1  one-cycle strobe: key_code/key_break valid
key_code  in  8  PS/2 set-2 scan code, prefix stripped
key_break  in  1  1 = release event, 0 = make event
collision  in  1  level from Model: car overlaps obstacle
status  out  4  game state encoding (below)
direction  out  4  {up,down,left,right} steering request
countdown  out  2  current countdown digit 3..1, 0 otherwise
level  out  3  speed level 0..7
score  out  16  4-digit packed BCD score
hiscore  out  16  packed BCD best score (only with BR_HISCORE_EN)

Behaviour:
- Reset: all registered state cleared.
  - status=0 (IDLE), direction=0, countdown=0, level=0, score=0, hiscore=0.
  - Frame counters and held-key register are cleared.
  - Reset wins over any same-cycle event.
- Outputs are registered. A transition triggered in cycle N is visible on status in cycle N+1.
- Key decode on key_valid:
  - ENTER=8'h5A, P=8'h4D, W=8'h1D, S=8'h1B, A=8'h1C, D=8'h23.
  - Start/pause keys act on make events only; break events of those keys are ignored.
- Held-key register: W/S/A/D make sets the bit; break clears it. It is tracked in every state.
- direction = held bits gated by status==PLAY; otherwise 4'b0.
  - If up and down are both held, both bits read 0; same rule for left and right.
- FSM (status code):
  - IDLE(0): ENTER make → COUNTDOWN; load countdown=3; clear the frame counter.
  - COUNTDOWN(1): every COUNT_FRAMES ticks, decrement countdown. A tick taken while countdown==1 → PLAY with countdown=0. Keys other than WASD are ignored.
  - PLAY(2), in priority order:
    - collision=1 → CRASH, checked before keys.
    - else P make → PAUSE.
    - Each frame_tick advances the score and level dividers.
  - PAUSE(3): counters frozen. P make → PLAY with divider phase preserved. ENTER is ignored.
  - CRASH(4): counts CRASH_FRAMES ticks, then → OVER. Keys and collision are ignored.
  - OVER(5): score and level held. ENTER make → IDLE, clearing score, level and dividers.
  - Codes 6–15 are unreachable; if entered, the FSM returns to IDLE on the next cycle.
- Score:
  - Packed BCD, +1 per SCORE_DIV PLAY ticks, ripple carry across digits.
  - Saturates at 16'h9999 with no wrap; the divider keeps running.
- Level: +1 per LEVEL_FRAMES PLAY ticks, saturates at 7.
- Frame counters use $clog2(param+1) bits. Each resets to 0 on terminal count and on every state entry, except a PAUSE→PLAY return.
- Same-cycle key_valid and frame_tick: both are processed. A key-driven transition takes priority, and the tick is not counted in the new state.

Optional Feature:
BR_HISCORE_EN:
- When defined: a hiscore register is updated on entry to OVER, if score > hiscore (BCD compare, MSD first).
  - Cleared only by clr; it survives OVER→IDLE.
  - The hiscore port exists.
- When undefined: no hiscore register and no hiscore port.

Test Plan:
- clr asserted mid-PLAY with score=16'h0042, level=2 → next cycle: status=0, score=0, level=0, direction=0, countdown=0.
- Overrides COUNT_FRAMES=2. ENTER make, then 6 frame_ticks → countdown goes 3,2,1 on ticks 0,2,4; status=2 after tick 6.
- PLAY, SCORE_DIV=1, score preloaded to 16'h0999 via 999 ticks, then 1 more tick → score=16'h1000. Continue to 16'h9999 plus 5 ticks → remains 16'h9999.
- PLAY, W make, A make, S make → direction=4'b0010; P make → status=3 and direction=0; P make again → direction=4'b0010.
- PLAY, collision=1 and P make in the same cycle → status=4. After CRASH_FRAMES=3 ticks → status=5; ENTER → status=0, score=0.
- BR_HISCORE_EN defined: game 1 ends at 16'h0025, game 2 at 16'h0017 → hiscore=16'h0025 after both games; clr → hiscore=0.
